// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data bus bundle between the MEM stage and the memory slave
interface mem_access_if;
   logic        req;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, sel, addr, wdata, input rdata, ack);
   modport slave  (input req, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: load/store/LL/SC bus sequencing, load alignment, LLbit
// Optional bus timeout compiled in by defining MEM_BUS_TIMEOUT_EN.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic        mem_whilo,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic [7:0]  mem_aluop,
   input  logic [31:0] mem_mem_addr,
   input  logic [31:0] mem_reg2,
   input  logic        mem_cp0_reg_we,
   input  logic [4:0]  mem_cp0_reg_write_addr,
   input  logic [31:0] mem_cp0_reg_data,
   input  logic [31:0] mem_excepttype,
   input  logic [31:0] mem_current_inst_address,
   input  logic        mem_is_in_delayslot,
   input  logic [7:0]  stall,
   input  logic        flush,
   mem_access_if.master dbus,
   output logic        stallreq,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        wb_whilo,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        wb_cp0_reg_we,
   output logic [4:0]  wb_cp0_reg_write_addr,
   output logic [31:0] wb_cp0_reg_data,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_address_o,
   output logic        is_in_delayslot_o
);
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LL  = 8'hF0;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;
   localparam logic [7:0] OP_SC  = 8'hF8;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;
   state_t state, state_next;

   logic is_load, is_store, is_byte, is_half, is_signed, is_ll, is_sc;
   logic is_mem, is_word, fault, exc_in, sc_fail, start;
   logic req, stall_c, bus_err, use_bus_q, bus_timeout;
   logic llbit;
   logic [31:0] rdata_q;
   logic        we_q;
   logic [3:0]  sel_q, sel_c;
   logic [31:0] addr_q, wdata_q, wdata_c;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_data;
   logic        sc_leave;
   logic        unused_stall;

   assign unused_stall = ^{stall[7], stall[5:0]};

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_signed = 1'b0;
      is_ll     = 1'b0;
      is_sc     = 1'b0;
      case (mem_aluop)
         OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
         OP_LH:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
         OP_LW:  is_load = 1'b1;
         OP_LL:  begin is_load = 1'b1; is_ll = 1'b1; end
         OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:  is_store = 1'b1;
         OP_SC:  begin is_store = 1'b1; is_sc = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem  = is_load | is_store;
   assign is_word = is_mem & ~is_byte & ~is_half;
   assign fault   = (is_half & mem_mem_addr[0]) | (is_word & (|mem_mem_addr[1:0]));
   assign exc_in  = |mem_excepttype;
   assign sc_fail = is_sc & ~llbit;
   assign start   = is_mem & ~fault & ~exc_in & ~sc_fail & ~flush;

   // Big-endian lanes: address 0 lives in bits [31:24].
   always_comb begin
      sel_c   = 4'b1111;
      wdata_c = mem_reg2;
      if (is_byte) begin
         sel_c   = 4'b1000 >> mem_mem_addr[1:0];
         wdata_c = {4{mem_reg2[7:0]}};
      end else if (is_half) begin
         sel_c   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
         wdata_c = {2{mem_reg2[15:0]}};
      end
   end

   assign byte_v = rdata_q[{~mem_mem_addr[1:0], 3'b000} +: 8];
   assign half_v = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];

   always_comb begin
      load_data = rdata_q;
      if (is_byte)
         load_data = {{24{is_signed & byte_v[7]}}, byte_v};
      else if (is_half)
         load_data = {{16{is_signed & half_v[15]}}, half_v};
   end

`ifdef MEM_BUS_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign bus_timeout = ((state == S_WAIT) || (state == S_DRAIN)) && (to_cnt >= TIMEOUT_CYCLES);

   always_ff @(posedge clk) begin
      if (rst || (state_next != state))
         to_cnt <= 32'd0;
      else if ((state == S_WAIT) || (state == S_DRAIN))
         to_cnt <= to_cnt + 32'd1;
   end
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
   assign bus_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // An ack always wins over a timeout, which in turn wins over a flush.
   always_comb begin
      state_next = state;
      req        = 1'b0;
      stall_c    = 1'b0;
      bus_err    = 1'b0;
      use_bus_q  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               req        = 1'b1;
               stall_c    = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT, S_DRAIN: begin
            req       = 1'b1;
            stall_c   = 1'b1;
            use_bus_q = 1'b1;
            if (dbus.ack) begin
               state_next = (state == S_WAIT && !flush) ? S_DONE : S_IDLE;
            end else if (bus_timeout) begin
               req        = 1'b0;
               stall_c    = 1'b0;
               bus_err    = 1'b1;
               state_next = S_IDLE;
            end else if (flush) begin
               state_next = S_DRAIN;
            end
         end
         S_DONE: begin
            if (flush || !stall[6])
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // An SC leaves the stage either straight from IDLE (no bus access) or from DONE.
   assign sc_leave = is_sc && !stall[6] && (((state == S_IDLE) && !start) || (state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'd0;
         llbit   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         if ((state == S_IDLE) && start) begin
            we_q    <= is_store;
            sel_q   <= sel_c;
            addr_q  <= {mem_mem_addr[31:2], 2'b00};
            wdata_q <= wdata_c;
         end
         if ((state == S_WAIT) && dbus.ack && !flush)
            rdata_q <= dbus.rdata;
         if (flush)
            llbit <= 1'b0;
         else if ((state == S_WAIT) && dbus.ack && is_ll)
            llbit <= 1'b1;
         else if (sc_leave)
            llbit <= 1'b0;
      end
   end

   always_comb begin
      dbus.req               = 1'b0;
      dbus.we                = 1'b0;
      dbus.sel               = 4'd0;
      dbus.addr              = 32'd0;
      dbus.wdata             = 32'd0;
      stallreq               = 1'b0;
      wb_wd                  = 5'd0;
      wb_wreg                = 1'b0;
      wb_wdata               = 32'd0;
      wb_whilo               = 1'b0;
      wb_hi                  = 32'd0;
      wb_lo                  = 32'd0;
      wb_cp0_reg_we          = 1'b0;
      wb_cp0_reg_write_addr  = 5'd0;
      wb_cp0_reg_data        = 32'd0;
      excepttype_o           = 32'd0;
      current_inst_address_o = 32'd0;
      is_in_delayslot_o      = 1'b0;
      if (!rst) begin
         dbus.req = req;
         if (use_bus_q) begin
            dbus.we    = we_q;
            dbus.sel   = sel_q;
            dbus.addr  = addr_q;
            dbus.wdata = wdata_q;
         end else if (req) begin
            dbus.we    = is_store;
            dbus.sel   = sel_c;
            dbus.addr  = {mem_mem_addr[31:2], 2'b00};
            dbus.wdata = wdata_c;
         end
         stallreq              = stall_c;
         wb_wd                 = mem_wd;
         wb_wreg               = mem_wreg & ~(is_mem & (fault | exc_in)) & ~bus_err;
         wb_wdata              = mem_wdata;
         if (is_sc)
            wb_wdata = {31'd0, llbit};
         else if (is_load)
            wb_wdata = load_data;
         wb_whilo              = mem_whilo;
         wb_hi                 = mem_hi;
         wb_lo                 = mem_lo;
         wb_cp0_reg_we         = mem_cp0_reg_we;
         wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
         wb_cp0_reg_data       = mem_cp0_reg_data;
         excepttype_o          = mem_excepttype;
         excepttype_o[13]      = mem_excepttype[13] | (fault & is_load);
         excepttype_o[14]      = mem_excepttype[14] | (fault & is_store);
         excepttype_o[15]      = mem_excepttype[15] | bus_err;
         current_inst_address_o = mem_current_inst_address;
         is_in_delayslot_o     = mem_is_in_delayslot;
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized bench for mem_access against a behavioural model
module tb_mem_access;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi, mem_lo;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr, mem_reg2;
   logic        mem_cp0_reg_we;
   logic [4:0]  mem_cp0_reg_write_addr;
   logic [31:0] mem_cp0_reg_data;
   logic [31:0] mem_excepttype, mem_current_inst_address;
   logic        mem_is_in_delayslot;
   logic [7:0]  stall;
   logic        flush;
   logic        stallreq;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        wb_whilo;
   logic [31:0] wb_hi, wb_lo;
   logic        wb_cp0_reg_we;
   logic [4:0]  wb_cp0_reg_write_addr;
   logic [31:0] wb_cp0_reg_data;
   logic [31:0] excepttype_o, current_inst_address_o;
   logic        is_in_delayslot_o;

   mem_access_if dbus ();

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
      .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
      .mem_cp0_reg_data(mem_cp0_reg_data), .mem_excepttype(mem_excepttype),
      .mem_current_inst_address(mem_current_inst_address), .mem_is_in_delayslot(mem_is_in_delayslot),
      .stall(stall), .flush(flush), .dbus(dbus), .stallreq(stallreq),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
      .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_cp0_reg_we(wb_cp0_reg_we),
      .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr), .wb_cp0_reg_data(wb_cp0_reg_data),
      .excepttype_o(excepttype_o), .current_inst_address_o(current_inst_address_o),
      .is_in_delayslot_o(is_in_delayslot_o)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit model_ll = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int op_size(input logic [7:0] op);
      case (op)
         8'hE0, 8'hE4, 8'hE8: return 1;
         8'hE1, 8'hE5, 8'hE9: return 2;
         default:             return 4;
      endcase
   endfunction

   function automatic bit op_load(input logic [7:0] op);
      return op inside {8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hF0};
   endfunction

   function automatic bit op_store(input logic [7:0] op);
      return op inside {8'hE8, 8'hE9, 8'hEB, 8'hF8};
   endfunction

   function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
      int sz;
      int lane;
      sz   = op_size(op);
      lane = int'(addr[1:0]);
      return 4'(((1 << sz) - 1) << (4 - sz - lane));
   endfunction

   function automatic logic [31:0] exp_store(input logic [7:0] op, input logic [31:0] reg2);
      case (op_size(op))
         1:       return {24'd0, reg2[7:0]} * 32'h0101_0101;
         2:       return {16'd0, reg2[15:0]} * 32'h0001_0001;
         default: return reg2;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata);
      int sz;
      int lane;
      logic [31:0] mask;
      logic [31:0] v;
      sz   = op_size(op);
      lane = int'(addr[1:0]);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (rdata >> (8 * (4 - sz - lane))) & mask;
      if ((op == 8'hE0 || op == 8'hE1) && v[8 * sz - 1])
         v = v | ~mask;
      return v;
   endfunction

   task automatic set_inputs(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2, input logic [31:0] exc);
      mem_aluop                = op;
      mem_mem_addr             = addr;
      mem_reg2                 = reg2;
      mem_excepttype           = exc;
      mem_wd                   = 5'($urandom);
      mem_wreg                 = 1'($urandom);
      mem_wdata                = $urandom;
      mem_whilo                = 1'($urandom);
      mem_hi                   = $urandom;
      mem_lo                   = $urandom;
      mem_cp0_reg_we           = 1'($urandom);
      mem_cp0_reg_write_addr   = 5'($urandom);
      mem_cp0_reg_data         = $urandom;
      mem_current_inst_address = $urandom;
      mem_is_in_delayslot      = 1'($urandom);
   endtask

   // Enters and leaves just after a rising edge; the bench plays the bus slave.
   task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input logic [31:0] exc, input int delay, input int hold);
      bit ld, st, mis, go;
      logic [31:0] exp_exc;
      ld  = op_load(op);
      st  = op_store(op);
      mis = (ld || st) && ((int'(addr[1:0]) % op_size(op)) != 0);
      go  = (ld || st) && !mis && (exc == 32'd0) && !(op == 8'hF8 && !model_ll);
      exp_exc = exc | ((mis && ld) ? 32'h0000_2000 : 32'd0) | ((mis && st) ? 32'h0000_4000 : 32'd0);
      set_inputs(op, addr, reg2, exc);
      @(negedge clk);
      check("issue_stallreq", 32'(stallreq), 32'(go));
      check("issue_req", 32'(dbus.req), 32'(go));
      check("excepttype", excepttype_o, exp_exc);
      check("wb_wreg", 32'(wb_wreg), 32'(mem_wreg && !((ld || st) && (mis || exc != 32'd0))));
      check("pass_hi", wb_hi, mem_hi);
      check("pass_cp0", wb_cp0_reg_data, mem_cp0_reg_data);
      check("pass_pc", current_inst_address_o, mem_current_inst_address);
      if (go) begin
         check("issue_sel", 32'(dbus.sel), 32'(exp_sel(op, addr)));
         check("issue_addr", dbus.addr, addr & ~32'd3);
         check("issue_we", 32'(dbus.we), 32'(st));
         if (st) check("issue_wdata", dbus.wdata, exp_store(op, reg2));
         for (int k = 1; k <= delay; k++) begin
            @(posedge clk); #1;
            dbus.ack   = (k == delay);
            dbus.rdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
            check("wait_stallreq", 32'(stallreq), 32'd1);
            check("wait_req", 32'(dbus.req), 32'd1);
            check("wait_addr", dbus.addr, addr & ~32'd3);
         end
         @(posedge clk); #1;
         dbus.ack = 1'b0;
         stall[6] = (hold > 0);
         for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            check("done_stallreq", 32'(stallreq), 32'd0);
            check("done_req", 32'(dbus.req), 32'd0);
            if (ld) check("done_load", wb_wdata, exp_load(op, addr, rdata));
            if (op == 8'hF8) check("done_sc", wb_wdata, 32'd1);
            @(posedge clk); #1;
            stall[6] = (h + 1 < hold);
         end
      end else begin
         if (op == 8'hF8) check("sc_nobus", wb_wdata, 32'(model_ll));
         else if (!ld && !st) check("pass_wdata", wb_wdata, mem_wdata);
         @(posedge clk); #1;
      end
      if (op == 8'hF0 && go) model_ll = 1'b1;
      if (op == 8'hF8) model_ll = 1'b0;
   endtask

   task automatic flush_in_wait(input bit same_cycle);
      set_inputs(8'hE3, 32'h0000_0400, 32'd0, 32'd0);
      @(negedge clk);
      check("fw_req", 32'(dbus.req), 32'd1);
      @(posedge clk); #1;
      flush      = 1'b1;
      dbus.ack   = same_cycle;
      dbus.rdata = $urandom;
      @(negedge clk);
      check("fw_stallreq", 32'(stallreq), 32'd1);
      @(posedge clk); #1;
      flush    = 1'b0;
      dbus.ack = 1'b0;
      set_inputs(8'h00, $urandom, $urandom, 32'd0);
      model_ll = 1'b0;
      if (!same_cycle) begin
         for (int k = 1; k <= 2; k++) begin
            dbus.ack = (k == 2);
            @(negedge clk);
            check("drain_req", 32'(dbus.req), 32'd1);
            check("drain_stallreq", 32'(stallreq), 32'd1);
            check("drain_addr", dbus.addr, 32'h0000_0400);
            @(posedge clk); #1;
            dbus.ack = 1'b0;
         end
      end
      @(negedge clk);
      check("post_flush_stallreq", 32'(stallreq), 32'd0);
      check("post_flush_req", 32'(dbus.req), 32'd0);
      check("post_flush_wdata", wb_wdata, mem_wdata);
      @(posedge clk); #1;
   endtask

   logic [7:0] ops [12] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hF0, 8'hE8, 8'hE9, 8'hEB, 8'hF8, 8'h21, 8'h00};

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      stall      = 8'd0;
      dbus.ack   = 1'b0;
      dbus.rdata = 32'd0;
      set_inputs(8'hE3, 32'h0000_0100, 32'h1234_5678, 32'h0000_0100);
      @(negedge clk);
      check("rst_stallreq", 32'(stallreq), 32'd0);
      check("rst_req", 32'(dbus.req), 32'd0);
      check("rst_wb_hi", wb_hi, 32'd0);
      check("rst_exc", excepttype_o, 32'd0);
      check("rst_pc", current_inst_address_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op(8'hE3, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 32'd0, 3, 0);
      run_op(8'hE0, 32'h0000_0103, 32'd0, 32'h1234_56F0, 32'd0, 1, 0);
      run_op(8'hE4, 32'h0000_0103, 32'd0, 32'h1234_56F0, 32'd0, 2, 1);
      run_op(8'hE9, 32'h0000_0202, 32'hAAAA_5555, 32'd0, 32'd0, 1, 0);
      run_op(8'hE3, 32'h0000_0101, 32'd0, 32'd0, 32'd0, 1, 0);
      run_op(8'hF0, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, 32'd0, 2, 0);
      run_op(8'hF8, 32'h0000_0300, 32'h1111_2222, 32'd0, 32'd0, 1, 2);
      run_op(8'hF8, 32'h0000_0300, 32'h1111_2222, 32'd0, 32'd0, 1, 0);
      run_op(8'hF0, 32'h0000_0300, 32'd0, 32'h5555_AAAA, 32'd0, 1, 0);
      set_inputs(8'h00, 32'd0, 32'd0, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      model_ll = 1'b0;
      run_op(8'hF8, 32'h0000_0300, 32'h1111_2222, 32'd0, 32'd0, 1, 0);

      flush_in_wait(1'b0);
      flush_in_wait(1'b1);

      set_inputs(8'hE3, 32'h0000_0500, 32'd0, 32'd0);
      @(negedge clk);
      check("rw_req", 32'(dbus.req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rw_stallreq", 32'(stallreq), 32'd0);
      check("rw_wb_wd", 32'(wb_wd), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_inputs(8'h00, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("rw_idle_stallreq", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
      run_op(8'hF0, 32'h0000_0600, 32'd0, 32'h0000_0001, 32'd0, 1, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      model_ll = 1'b0;
      run_op(8'hF8, 32'h0000_0600, 32'h0000_0042, 32'd0, 32'd0, 1, 0);

`ifdef MEM_BUS_TIMEOUT_EN
      set_inputs(8'hE3, 32'h0000_0700, 32'd0, 32'd0);
      @(negedge clk);
      check("to_req", 32'(dbus.req), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("to_wait_stallreq", 32'(stallreq), 32'd1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("to_bit15", 32'(excepttype_o[15]), 32'd1);
      check("to_req_drop", 32'(dbus.req), 32'd0);
      check("to_stallreq", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
      set_inputs(8'h00, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("to_idle", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
`endif

      for (int i = 0; i < 60; i++) begin
         logic [7:0]  op;
         logic [31:0] addr;
         op   = ops[$urandom_range(0, 11)];
         addr = $urandom;
         if ($urandom_range(0, 3) != 0)
            addr = addr & ~32'(op_size(op) - 1);
         run_op(op, addr, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 32'h0000_0100 : 32'd0,
                int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
